// File: rtl/arfs_tbl_arbiter.sv
// Flow-steering table arbiter: flushes the table RAM, then arbitrates single-port
// access between a pipelined lookup path and an update path with starvation guard.
module arfs_tbl_arbiter #(
   parameter int unsigned IDX_W        = 10,
   parameter int unsigned TAG_W        = 32,
   parameter int unsigned QID_W        = 11,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned DEFAULT_QID  = 0
) (
   input  logic                     axis_aclk,
   input  logic                     axis_areset,
   input  logic                     lkp_valid,
   output logic                     lkp_ready,
   input  logic [IDX_W-1:0]         lkp_idx,
   input  logic [TAG_W-1:0]         lkp_tag,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic                     res_hit,
   output logic [QID_W-1:0]         res_qid,
   input  logic                     upd_valid,
   output logic                     upd_ready,
   input  logic [IDX_W-1:0]         upd_idx,
   input  logic [TAG_W-1:0]         upd_tag,
   input  logic [QID_W-1:0]         upd_qid,
   input  logic                     upd_del,
   output logic                     ram_en,
   output logic                     ram_we,
   output logic [IDX_W-1:0]         ram_addr,
   output logic [1+TAG_W+QID_W-1:0] ram_wdata,
   input  logic [1+TAG_W+QID_W-1:0] ram_rdata,
   input  logic                     flush_req,
   output logic                     flush_busy,
   output logic [31:0]              stat_hits,
   output logic [31:0]              stat_misses
);

   localparam int unsigned ST_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
      logic [QID_W-1:0] qid;
   } entry_t;

   typedef enum logic {FLUSH, RUN} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   flush_addr_q, flush_addr_d;
   logic [ST_W-1:0]    starve_q, starve_d;
   logic               s1_valid_q, s1_valid_d;
   logic               s1_rd_q, s1_rd_d;
   logic [TAG_W-1:0]   s1_tag_q, s1_tag_d;
   logic               s1_hit_q, s1_hit_d;
   logic [QID_W-1:0]   s1_qid_q, s1_qid_d;
   logic               res_valid_q, res_valid_d;
   logic               res_hit_q, res_hit_d;
   logic [QID_W-1:0]   res_qid_q, res_qid_d;
   logic [31:0]        hits_q, hits_d;
   logic [31:0]        misses_q, misses_d;

   entry_t             rd_ent, upd_ent;
   logic               run_c, slot_ok_c, res_load_c, upd_grant_c, lkp_grant_c;
   logic               s1_hit_c;
   logic [QID_W-1:0]   s1_qid_c;

   // Arbitration, RAM drive, lookup pipeline and FSM next-state
   always_comb begin
      state_d      = state_q;
      flush_addr_d = flush_addr_q;
      starve_d     = starve_q;
      s1_valid_d   = s1_valid_q;
      s1_rd_d      = 1'b0;
      s1_tag_d     = s1_tag_q;
      res_valid_d  = res_valid_q;
      res_hit_d    = res_hit_q;
      res_qid_d    = res_qid_q;
      hits_d       = hits_q;
      misses_d     = misses_q;
      ram_en       = 1'b0;
      ram_we       = 1'b0;
      ram_addr     = '0;
      ram_wdata    = '0;

      rd_ent  = entry_t'(ram_rdata);
      upd_ent = '{vld: 1'b1, tag: upd_tag, qid: upd_qid};

      // Compare only in the cycle the read data is live; otherwise keep the held result
      if (s1_rd_q) begin
         s1_hit_c = rd_ent.vld && (rd_ent.tag == s1_tag_q);
         s1_qid_c = s1_hit_c ? rd_ent.qid : QID_W'(DEFAULT_QID);
      end else begin
         s1_hit_c = s1_hit_q;
         s1_qid_c = s1_qid_q;
      end
      s1_hit_d = s1_hit_c;
      s1_qid_d = s1_qid_c;

      run_c       = !axis_areset && (state_q == RUN);
      res_load_c  = s1_valid_q && (!res_valid_q || res_ready);
      slot_ok_c   = !s1_valid_q || !res_valid_q || res_ready;
      upd_grant_c = run_c && upd_valid &&
                    (!(lkp_valid && slot_ok_c) || (starve_q == ST_W'(STARVE_LIMIT)));
      lkp_grant_c = run_c && lkp_valid && slot_ok_c && !upd_grant_c;

      lkp_ready  = run_c && slot_ok_c && !upd_grant_c;
      upd_ready  = upd_grant_c;
      flush_busy = axis_areset || (state_q == FLUSH);

      if (!axis_areset && (state_q == FLUSH)) begin
         ram_en   = 1'b1;
         ram_we   = 1'b1;
         ram_addr = flush_addr_q;
      end else if (upd_grant_c) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_addr  = upd_idx;
         ram_wdata = upd_del ? '0 : upd_ent;
      end else if (lkp_grant_c) begin
         ram_en   = 1'b1;
         ram_addr = lkp_idx;
      end

      case (state_q)
         FLUSH: begin
            flush_addr_d = flush_addr_q + IDX_W'(1);
            if (flush_addr_q == '1) state_d = RUN;
         end
         RUN: begin
            if (flush_req) begin
               state_d      = FLUSH;
               flush_addr_d = '0;
            end
         end
         default: state_d = FLUSH;
      endcase

      if (upd_grant_c || !upd_valid)
         starve_d = '0;
      else if (lkp_grant_c && (starve_q != ST_W'(STARVE_LIMIT)))
         starve_d = starve_q + ST_W'(1);

      s1_rd_d    = lkp_grant_c;
      s1_valid_d = lkp_grant_c || (s1_valid_q && !res_load_c);
      if (lkp_grant_c) s1_tag_d = lkp_tag;

      if (res_load_c) begin
         res_valid_d = 1'b1;
         res_hit_d   = s1_hit_c;
         res_qid_d   = s1_qid_c;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end

      if (res_valid_q && res_ready) begin
         if (res_hit_q) hits_d   = hits_q + 32'd1;
         else           misses_d = misses_q + 32'd1;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q      <= FLUSH;
         flush_addr_q <= '0;
         starve_q     <= '0;
         s1_valid_q   <= 1'b0;
         s1_rd_q      <= 1'b0;
         s1_tag_q     <= '0;
         s1_hit_q     <= 1'b0;
         s1_qid_q     <= QID_W'(DEFAULT_QID);
         res_valid_q  <= 1'b0;
         res_hit_q    <= 1'b0;
         res_qid_q    <= QID_W'(DEFAULT_QID);
         hits_q       <= '0;
         misses_q     <= '0;
      end else begin
         state_q      <= state_d;
         flush_addr_q <= flush_addr_d;
         starve_q     <= starve_d;
         s1_valid_q   <= s1_valid_d;
         s1_rd_q      <= s1_rd_d;
         s1_tag_q     <= s1_tag_d;
         s1_hit_q     <= s1_hit_d;
         s1_qid_q     <= s1_qid_d;
         res_valid_q  <= res_valid_d;
         res_hit_q    <= res_hit_d;
         res_qid_q    <= res_qid_d;
         hits_q       <= hits_d;
         misses_q     <= misses_d;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_hit     = res_hit_q;
   assign res_qid     = res_qid_q;
   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;

endmodule

// File: tb/tb_arfs_tbl_arbiter.sv
// Directed bench for arfs_tbl_arbiter with a behavioural 1-cycle-latency table RAM.
module tb_arfs_tbl_arbiter;

   localparam int unsigned IDX_W = 10;
   localparam int unsigned TAG_W = 32;
   localparam int unsigned QID_W = 11;
   localparam int unsigned ENT_W = 1 + TAG_W + QID_W;
   localparam int unsigned DEPTH = 1 << IDX_W;

   logic             axis_aclk = 1'b0;
   logic             axis_areset;
   logic             lkp_valid, lkp_ready;
   logic [IDX_W-1:0] lkp_idx;
   logic [TAG_W-1:0] lkp_tag;
   logic             res_valid, res_ready, res_hit;
   logic [QID_W-1:0] res_qid;
   logic             upd_valid, upd_ready, upd_del;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic [QID_W-1:0] upd_qid;
   logic             ram_en, ram_we;
   logic [IDX_W-1:0] ram_addr;
   logic [ENT_W-1:0] ram_wdata, ram_rdata;
   logic             flush_req, flush_busy;
   logic [31:0]      stat_hits, stat_misses;

   logic             tb_init;
   logic [ENT_W-1:0] mem [DEPTH];

   int checks = 0;
   int errors = 0;
   int n, bad, rdy, nz, upd_cycle, nacc, nres, sent, drop, unstable, have_prev, lr_at_upd;
   logic             ph;
   logic [QID_W-1:0] pq;
   logic [QID_W:0]   got [32];

   arfs_tbl_arbiter dut (
      .axis_aclk(axis_aclk), .axis_areset(axis_areset),
      .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_idx(lkp_idx), .lkp_tag(lkp_tag),
      .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_qid(res_qid),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_tag(upd_tag),
      .upd_qid(upd_qid), .upd_del(upd_del),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata),
      .flush_req(flush_req), .flush_busy(flush_busy),
      .stat_hits(stat_hits), .stat_misses(stat_misses)
   );

   always #5 axis_aclk = ~axis_aclk;

   // Table RAM; preloaded with valid garbage so only a real flush clears it
   always @(posedge axis_aclk) begin
      if (tb_init) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= {1'b1, 32'h2e2f90fa, QID_W'(i)};
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge axis_aclk);
      #1;
   endtask

   // Called at the sample point of the first flush cycle; returns at the first RUN cycle
   task automatic wait_flush(output int cyc, output int badw, output int rdyh);
      cyc = 0; badw = 0; rdyh = 0;
      while (flush_busy && cyc < 2000) begin
         if (!(ram_en === 1'b1 && ram_we === 1'b1 && ram_addr === IDX_W'(cyc) && ram_wdata === '0))
            badw++;
         if (lkp_ready !== 1'b0) rdyh++;
         cyc++;
         next_cycle();
         #1;
      end
   endtask

   task automatic do_upd(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                         input logic [QID_W-1:0] qid, input logic del);
      next_cycle();
      upd_valid = 1'b1; upd_idx = idx; upd_tag = tag; upd_qid = qid; upd_del = del;
      #1;
      chk("upd_ready", 64'(upd_ready), 64'd1);
      next_cycle();
      upd_valid = 1'b0; upd_del = 1'b0;
      #1;
   endtask

   task automatic do_lkp(input string tag_s, input logic [IDX_W-1:0] idx,
                         input logic [TAG_W-1:0] tag, input logic ehit, input logic [QID_W-1:0] eqid);
      next_cycle();
      lkp_valid = 1'b1; lkp_idx = idx; lkp_tag = tag; res_ready = 1'b1;
      #1;
      chk({tag_s, "_lkp_ready"}, 64'(lkp_ready), 64'd1);
      next_cycle();
      lkp_valid = 1'b0;
      #1;
      chk({tag_s, "_res_early"}, 64'(res_valid), 64'd0);
      next_cycle();
      #1;
      chk({tag_s, "_res_valid"}, 64'(res_valid), 64'd1);
      chk({tag_s, "_res_hit"},   64'(res_hit), 64'(ehit));
      chk({tag_s, "_res_qid"},   64'(res_qid), 64'(eqid));
      next_cycle();
      #1;
   endtask

   initial begin
      axis_areset = 1'b1; tb_init = 1'b1;
      lkp_valid = 1'b0; lkp_idx = '0; lkp_tag = '0; res_ready = 1'b1;
      upd_valid = 1'b0; upd_idx = '0; upd_tag = '0; upd_qid = '0; upd_del = 1'b0;
      flush_req = 1'b0;
      next_cycle();
      tb_init = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      chk("rst_res_valid",  64'(res_valid), 64'd0);
      chk("rst_res_hit",    64'(res_hit), 64'd0);
      chk("rst_res_qid",    64'(res_qid), 64'd0);
      chk("rst_lkp_ready",  64'(lkp_ready), 64'd0);
      chk("rst_upd_ready",  64'(upd_ready), 64'd0);
      chk("rst_ram_en",     64'(ram_en), 64'd0);
      chk("rst_ram_we",     64'(ram_we), 64'd0);
      chk("rst_flush_busy", 64'(flush_busy), 64'd1);
      chk("rst_hits",       64'(stat_hits), 64'd0);
      chk("rst_misses",     64'(stat_misses), 64'd0);

      next_cycle();
      axis_areset = 1'b0;
      #1;
      wait_flush(n, bad, rdy);
      chk("flush_cycles", 64'(n), 64'd1024);
      chk("flush_writes", 64'(bad), 64'd0);
      chk("flush_lkp_ready", 64'(rdy), 64'd0);
      nz = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
      chk("table_zeroed", 64'(nz), 64'd0);
      chk("run_flush_busy", 64'(flush_busy), 64'd0);
      chk("run_lkp_ready", 64'(lkp_ready), 64'd1);

      // Insert, hit, mismatched tag, delete
      do_upd(10'h005, 32'h2e2f90fa, 11'h0fa, 1'b0);
      do_lkp("hit1", 10'h005, 32'h2e2f90fa, 1'b1, 11'h0fa);
      chk("hits_1", 64'(stat_hits), 64'd1);
      do_lkp("tagmiss", 10'h005, 32'h2e2f90fd, 1'b0, 11'h000);
      chk("misses_1", 64'(stat_misses), 64'd1);
      do_upd(10'h005, 32'h2e2f90fa, 11'h0fa, 1'b1);
      do_lkp("delmiss", 10'h005, 32'h2e2f90fa, 1'b0, 11'h000);
      chk("misses_2", 64'(stat_misses), 64'd2);

      // Re-insert, reach three hits, then flush
      do_upd(10'h005, 32'h2e2f90fa, 11'h0fa, 1'b0);
      do_lkp("hit2", 10'h005, 32'h2e2f90fa, 1'b1, 11'h0fa);
      do_lkp("hit3", 10'h005, 32'h2e2f90fa, 1'b1, 11'h0fa);
      chk("hits_3", 64'(stat_hits), 64'd3);
      next_cycle();
      flush_req = 1'b1;
      #1;
      next_cycle();
      flush_req = 1'b0;
      #1;
      wait_flush(n, bad, rdy);
      chk("reflush_cycles", 64'(n), 64'd1024);
      chk("reflush_writes", 64'(bad), 64'd0);
      chk("flush_hits_kept", 64'(stat_hits), 64'd3);
      chk("flush_misses_kept", 64'(stat_misses), 64'd2);
      do_lkp("postflush", 10'h005, 32'h2e2f90fa, 1'b0, 11'h000);
      chk("misses_3", 64'(stat_misses), 64'd3);

      // Starvation: update waits exactly STARVE_LIMIT lookup grants
      do_upd(10'h005, 32'h2e2f90fa, 11'h0fa, 1'b0);
      upd_cycle = -1; nacc = 0; nres = 0; lr_at_upd = -1;
      for (int c = 0; c < 20; c++) begin
         next_cycle();
         lkp_valid = (c < 11); lkp_idx = 10'h005; lkp_tag = 32'h2e2f90fa; res_ready = 1'b1;
         upd_valid = (upd_cycle < 0); upd_idx = 10'h005; upd_tag = 32'h2e2f90fa;
         upd_qid = 11'h0fb; upd_del = 1'b0;
         #1;
         if (upd_ready) begin upd_cycle = c; lr_at_upd = int'(lkp_ready); end
         if (lkp_valid && lkp_ready) nacc++;
         if (res_valid && nres < 32) begin got[nres] = {res_hit, res_qid}; nres++; end
      end
      upd_valid = 1'b0; lkp_valid = 1'b0;
      chk("starve_upd_cycle", 64'(upd_cycle), 64'd8);
      chk("starve_lkp_ready_at_upd", 64'(lr_at_upd), 64'd0);
      chk("starve_accepts", 64'(nacc), 64'd10);
      chk("starve_results", 64'(nres), 64'd10);
      for (int i = 0; i < 10; i++)
         chk($sformatf("starve_res%0d", i), 64'(got[i]), 64'({1'b1, (i < 8) ? 11'h0fa : 11'h0fb}));

      // Backpressure: res_ready low for 5 cycles mid-stream; alternate hit/miss
      sent = 0; nres = 0; drop = 0; unstable = 0; have_prev = 0; ph = 1'b0; pq = '0;
      for (int c = 0; c < 40; c++) begin
         next_cycle();
         lkp_valid = (sent < 8); lkp_idx = 10'h005;
         lkp_tag = sent[0] ? 32'h2e2f90fd : 32'h2e2f90fa;
         res_ready = !(c >= 3 && c < 8);
         #1;
         if (res_valid) begin
            if (have_prev != 0 && (res_hit !== ph || res_qid !== pq)) unstable++;
            if (res_ready) begin
               if (nres < 32) got[nres] = {res_hit, res_qid};
               nres++;
               have_prev = 0;
            end else begin
               have_prev = 1; ph = res_hit; pq = res_qid;
            end
         end
         if (lkp_valid && !lkp_ready) drop++;
         if (lkp_valid && lkp_ready) sent++;
      end
      lkp_valid = 1'b0; res_ready = 1'b1;
      chk("bp_lkp_ready_dropped", 64'(drop != 0), 64'd1);
      chk("bp_res_stable", 64'(unstable), 64'd0);
      chk("bp_results", 64'(nres), 64'd8);
      for (int i = 0; i < 8; i++)
         chk($sformatf("bp_res%0d", i), 64'(got[i]), 64'((i % 2 == 0) ? {1'b1, 11'h0fb} : {1'b0, 11'h000}));
      chk("final_hits", 64'(stat_hits), 64'd17);
      chk("final_misses", 64'(stat_misses), 64'd7);

      // Reset in the middle of a flush restarts it from address 0
      next_cycle();
      flush_req = 1'b1;
      #1;
      next_cycle();
      flush_req = 1'b0;
      for (int i = 0; i < 50; i++) next_cycle();
      axis_areset = 1'b1;
      next_cycle();
      #1;
      chk("midrst_flush_busy", 64'(flush_busy), 64'd1);
      chk("midrst_ram_en", 64'(ram_en), 64'd0);
      chk("midrst_hits", 64'(stat_hits), 64'd0);
      chk("midrst_res_valid", 64'(res_valid), 64'd0);
      next_cycle();
      axis_areset = 1'b0;
      #1;
      chk("midrst_addr0", 64'(ram_addr), 64'd0);
      wait_flush(n, bad, rdy);
      chk("midrst_flush_cycles", 64'(n), 64'd1024);
      chk("midrst_flush_writes", 64'(bad), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
